// File: rtl/pip_wb_stage.sv
// ---------------------------------------------------------------------------
// pip_wb_stage
// MEM/WB pipeline stage built from DEPTH register slices. It carries the
// writeback word, register addresses and the qualified rdEn/DMread controls
// from memory to writeback. It adds a valid bit, stall/flush control,
// x0-write suppression and a retired-instruction counter.
//
// Optional feature macro: PIP_WB_FWD_EN
//   When defined, the ports ex_rs1_ad/ex_rs2_ad and fwd_rs1/fwd_rs2 exist.
//   The fwd_* outputs are combinational forwarding-match flags for EX.
//
// Parameters
//   XLEN   : writeback data width
//   REG_AW : register address width
//   DEPTH  : number of register slices, legal range 1..4
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   stall, flush         : hold / invalidate every slice (flush wins)
//   valid                : incoming instruction is real
//   rd                   : writeback data
//   rs1_ad, rs2_ad, rd_ad: source and destination register addresses
//   rdEn, DMread         : register-file write enable, load flag
//   valid_p ... DMread_p : registered outputs of the last slice
//   retire_cnt           : retired-instruction count, wraps at 2^32
//   ex_rs1_ad, ex_rs2_ad : EX-stage sources (PIP_WB_FWD_EN)
//   fwd_rs1, fwd_rs2     : forwarding match flags (PIP_WB_FWD_EN)
// ---------------------------------------------------------------------------
module pip_wb_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid,
  input  logic [XLEN-1:0]   rd,
  input  logic [REG_AW-1:0] rs1_ad,
  input  logic [REG_AW-1:0] rs2_ad,
  input  logic [REG_AW-1:0] rd_ad,
  input  logic              rdEn,
  input  logic              DMread,
  output logic              valid_p,
  output logic [XLEN-1:0]   rd_p,
  output logic [REG_AW-1:0] rs1_ad_p,
  output logic [REG_AW-1:0] rs2_ad_p,
  output logic [REG_AW-1:0] rd_ad_p,
  output logic              rdEn_p,
  output logic              DMread_p,
  output logic [31:0]       retire_cnt
`ifdef PIP_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] ex_rs1_ad,
  input  logic [REG_AW-1:0] ex_rs2_ad,
  output logic              fwd_rs1,
  output logic              fwd_rs2
`endif
);

  localparam int unsigned LAST  = DEPTH - 1;
  localparam int unsigned CNT_W = 32;

  // Reject illegal slice counts at elaboration time.
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pip_wb_stage: DEPTH must be in 1..4");
    end
  endgenerate

  logic              r_valid  [DEPTH];
  logic [XLEN-1:0]   r_rd     [DEPTH];
  logic [REG_AW-1:0] r_rs1_ad [DEPTH];
  logic [REG_AW-1:0] r_rs2_ad [DEPTH];
  logic [REG_AW-1:0] r_rd_ad  [DEPTH];
  logic              r_rden   [DEPTH];
  logic              r_dmread [DEPTH];
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_rden_q;
  logic              w_dmread_q;
  logic              w_retire;

  // Controls are qualified once at entry; x0 writes never reach the regfile.
  assign w_rden_q   = rdEn & valid & (rd_ad != REG_AW'(0));
  assign w_dmread_q = DMread & valid;

  // The output instruction completes writeback on every non-stalled edge,
  // including a flush edge.
  assign w_retire   = r_valid[LAST] & ~stall;

  // Slice chain and retire counter; priority rst > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_valid[k]  <= 1'b0;
        r_rd[k]     <= '0;
        r_rs1_ad[k] <= '0;
        r_rs2_ad[k] <= '0;
        r_rd_ad[k]  <= '0;
        r_rden[k]   <= 1'b0;
        r_dmread[k] <= 1'b0;
      end
      r_retire_cnt <= '0;
    end else begin
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if (flush) begin
        // Data and addresses are left as-is; only the qualifiers drop.
        for (int k = 0; k < int'(DEPTH); k++) begin
          r_valid[k]  <= 1'b0;
          r_rden[k]   <= 1'b0;
          r_dmread[k] <= 1'b0;
        end
      end else if (!stall) begin
        r_valid[0]  <= valid;
        r_rd[0]     <= rd;
        r_rs1_ad[0] <= rs1_ad;
        r_rs2_ad[0] <= rs2_ad;
        r_rd_ad[0]  <= rd_ad;
        r_rden[0]   <= w_rden_q;
        r_dmread[0] <= w_dmread_q;
        for (int k = 1; k < int'(DEPTH); k++) begin
          r_valid[k]  <= r_valid[k-1];
          r_rd[k]     <= r_rd[k-1];
          r_rs1_ad[k] <= r_rs1_ad[k-1];
          r_rs2_ad[k] <= r_rs2_ad[k-1];
          r_rd_ad[k]  <= r_rd_ad[k-1];
          r_rden[k]   <= r_rden[k-1];
          r_dmread[k] <= r_dmread[k-1];
        end
      end
    end
  end

  assign valid_p    = r_valid[LAST];
  assign rd_p       = r_rd[LAST];
  assign rs1_ad_p   = r_rs1_ad[LAST];
  assign rs2_ad_p   = r_rs2_ad[LAST];
  assign rd_ad_p    = r_rd_ad[LAST];
  assign rdEn_p     = r_rden[LAST];
  assign DMread_p   = r_dmread[LAST];
  assign retire_cnt = r_retire_cnt;

`ifdef PIP_WB_FWD_EN
  // rdEn already excludes x0, so no separate zero-address check is needed.
  assign fwd_rs1 = r_valid[LAST] & r_rden[LAST] & (r_rd_ad[LAST] == ex_rs1_ad);
  assign fwd_rs2 = r_valid[LAST] & r_rden[LAST] & (r_rd_ad[LAST] == ex_rs2_ad);
`endif

endmodule
